// File: rtl/st_to_mm_fifo_bridge.sv
// rtl/st_to_mm_fifo_bridge.sv - Avalon-ST sink to Avalon-MM read-slave FIFO bridge with CSR window
//
// Streaming producer pushes words through st_*; the bus master pops them from
// address 0 with show-ahead semantics. Addresses 1..3 are STATUS, AFULL
// threshold and CTRL (flush / irq enable / clear back-pressure sticky).

module st_to_mm_fifo_bridge #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int LVL_W     = $clog2(DEPTH) + 1,
  parameter int AFULL_RST = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        mm_address,
  input  logic              mm_read,
  input  logic              mm_write,
  input  logic [31:0]       mm_writedata,
  output logic [31:0]       mm_readdata,
  output logic              mm_waitrequest,
  output logic              irq
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_AFULL  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  afull;
  logic [LVL_W-1:0]  afull_wval;
  logic [LVL_W-1:0]  afull_clamped;
  logic              irq_en;
  logic              bp_sticky;
  logic              irq_q;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              data_rd;
  logic              afull_wr;
  logic              ctrl_wr;
  logic              flush;
  logic              stall;
  logic              afull_flag;
  logic [DATA_W-1:0] head;
  logic [31:0]       status;

  // Only the low bits of writedata are meaningful to any register.
  logic              unused_wdata;
  assign unused_wdata = ^mm_writedata;

  assign full       = (level == LVL_W'(DEPTH));
  assign empty      = (level == '0);
  assign afull_flag = (level >= afull);

  // Ready is forced low during reset so nothing is accepted into a dead FIFO.
  assign st_ready = reset_n & ~full;
  assign push     = st_valid & st_ready;
  assign stall    = st_valid & ~st_ready;

  assign data_rd  = mm_read & (mm_address == ADDR_DATA);
  assign pop      = data_rd & ~empty;
  assign afull_wr = mm_write & (mm_address == ADDR_AFULL);
  assign ctrl_wr  = mm_write & (mm_address == ADDR_CTRL);
  assign flush    = ctrl_wr & mm_writedata[0];

  // A DATA read on an empty FIFO stalls the master; reset releases it at once.
  assign mm_waitrequest = reset_n & data_rd & empty;

  assign irq = irq_q;

  // Show-ahead head: asynchronous read of the register array, so a word
  // written at edge N is visible to the master during cycle N+1.
  assign head = mem[rd_ptr];

  assign status = {bp_sticky, afull_flag, full, empty, 12'b0, 16'(level)};

  // Threshold writes are clamped into 1..DEPTH so the flag is always reachable.
  always_comb begin
    afull_wval    = mm_writedata[LVL_W-1:0];
    afull_clamped = afull_wval;
    if (afull_wval == '0) begin
      afull_clamped = LVL_W'(1);
    end else if (afull_wval > LVL_W'(DEPTH)) begin
      afull_clamped = LVL_W'(DEPTH);
    end
  end

  // Read-data mux for the CSR window; DATA is zero-extended to 32 bits.
  always_comb begin
    mm_readdata = 32'b0;
    case (mm_address)
      ADDR_DATA:   mm_readdata = 32'(head);
      ADDR_STATUS: mm_readdata = status;
      ADDR_AFULL:  mm_readdata = 32'(afull);
      ADDR_CTRL:   mm_readdata = {30'b0, irq_en, 1'b0};
      default:     mm_readdata = 32'b0;
    endcase
  end

  // Storage write; content is not reset, pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= st_data;
    end
  end

  // Pointers and level; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // Control registers: threshold and interrupt enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      afull  <= LVL_W'(AFULL_RST);
      irq_en <= 1'b0;
    end else begin
      if (afull_wr) begin
        afull <= afull_clamped;
      end
      if (ctrl_wr) begin
        irq_en <= mm_writedata[1];
      end
    end
  end

  // Back-pressure sticky: a fresh stall outranks a software clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bp_sticky <= 1'b0;
    end else if (stall) begin
      bp_sticky <= 1'b1;
    end else if (ctrl_wr && mm_writedata[2]) begin
      bp_sticky <= 1'b0;
    end
  end

  // Registered level interrupt, one cycle behind the level it reflects.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en & afull_flag;
    end
  end

endmodule

// File: tb/tb_st_to_mm_fifo_bridge.sv
// tb/tb_st_to_mm_fifo_bridge.sv - self-checking bench for st_to_mm_fifo_bridge against a queue model

module tb_st_to_mm_fifo_bridge;

  localparam int DATA_W    = 12;
  localparam int DEPTH     = 32;
  localparam int LVL_W     = $clog2(DEPTH) + 1;
  localparam int AFULL_RST = 24;

  logic              clock;
  logic              reset_n;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
  logic [1:0]        mm_address;
  logic              mm_read;
  logic              mm_write;
  logic [31:0]       mm_writedata;
  logic [31:0]       mm_readdata;
  logic              mm_waitrequest;
  logic              irq;

  st_to_mm_fifo_bridge #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W), .AFULL_RST(AFULL_RST)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .mm_address(mm_address), .mm_read(mm_read), .mm_write(mm_write),
    .mm_writedata(mm_writedata), .mm_readdata(mm_readdata),
    .mm_waitrequest(mm_waitrequest), .irq(irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  int afull_m;
  bit irq_en_m;
  bit bp_m;
  bit irq_m;

  logic [31:0] last_rd;
  logic        last_wait;
  logic        last_ready;
  logic        last_irq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    int n;
    n = q.size();
    case (a)
      2'd0:    return (n > 0) ? 32'(q[0]) : 32'h0;
      2'd1:    return {bp_m, n >= afull_m, n == DEPTH, n == 0, 12'h0, 16'(n)};
      2'd2:    return 32'(afull_m);
      default: return {30'b0, irq_en_m, 1'b0};
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    afull_m  = AFULL_RST;
    irq_en_m = 1'b0;
    bp_m     = 1'b0;
    irq_m    = 1'b0;
  endtask

  // Check outputs mid-low-phase, then advance one clock and update the model.
  task automatic step();
    int n;
    int v;
    bit push;
    bit pop;
    bit stalled;
    bit waiting;
    #1;
    n = q.size();
    last_ready = st_ready;
    last_irq   = irq;
    last_rd    = mm_readdata;
    last_wait  = mm_waitrequest;
    chk("st_ready", 32'(st_ready), 32'(n != DEPTH));
    chk("irq", 32'(irq), 32'(irq_m));
    if (mm_read) begin
      waiting = (mm_address == 2'd0) && (n == 0);
      chk("waitrequest", 32'(mm_waitrequest), 32'(waiting));
      if (!waiting) begin
        chk($sformatf("readdata@%0d", mm_address), mm_readdata, model_rd(mm_address));
      end
    end
    @(posedge clock);
    push    = st_valid && (n != DEPTH);
    stalled = st_valid && (n == DEPTH);
    pop     = mm_read && (mm_address == 2'd0) && (n != 0);
    irq_m   = irq_en_m && (n >= afull_m);
    if (stalled) bp_m = 1'b1;
    else if (mm_write && mm_address == 2'd3 && mm_writedata[2]) bp_m = 1'b0;
    if (mm_write && mm_address == 2'd2) begin
      v = int'(mm_writedata[LVL_W-1:0]);
      afull_m = (v == 0) ? 1 : ((v > DEPTH) ? DEPTH : v);
    end
    if (mm_write && mm_address == 2'd3) irq_en_m = mm_writedata[1];
    if (mm_write && mm_address == 2'd3 && mm_writedata[0]) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(st_data);
    end
    @(negedge clock);
  endtask

  task automatic idle();
    st_valid = 1'b0; mm_read = 1'b0; mm_write = 1'b0;
    step();
  endtask

  task automatic push_w(input logic [DATA_W-1:0] d);
    st_valid = 1'b1; st_data = d; mm_read = 1'b0; mm_write = 1'b0;
    step();
    st_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    mm_read = 1'b1; mm_write = 1'b0; mm_address = a;
    step();
    mm_read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    mm_write = 1'b1; mm_read = 1'b0; mm_address = a; mm_writedata = d;
    step();
    mm_write = 1'b0;
  endtask

  task automatic drain();
    while (q.size() > 0) rd(2'd0);
  endtask

  initial begin
    reset_n = 1'b0; st_valid = 1'b0; st_data = '0;
    mm_address = 2'd0; mm_read = 1'b1; mm_write = 1'b0; mm_writedata = '0;
    model_reset();

    // Reset state: ready/irq/waitrequest all low even with a DATA read pending.
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("rst_st_ready", 32'(st_ready), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_waitrequest", 32'(mm_waitrequest), 32'd0);
    @(negedge clock);
    reset_n = 1'b1; mm_read = 1'b0;
    rd(2'd1); chk("rst_status", last_rd, 32'h1000_0000);
    rd(2'd2); chk("rst_afull", last_rd, 32'd24);
    rd(2'd3); chk("rst_ctrl", last_rd, 32'd0);

    // 1: push A0..A4 and read them back in order.
    for (int i = 0; i < 5; i++) push_w(DATA_W'(12'hA0 + i));
    rd(2'd1); chk("t1_status", last_rd, 32'h0000_0005);
    for (int i = 0; i < 5; i++) begin
      rd(2'd0); chk("t1_data", last_rd, 32'(12'hA0 + i));
    end
    rd(2'd1); chk("t1_empty", 32'(last_rd[28]), 32'd1);

    // 2: overfill with continuous valid, then one pop releases ready.
    for (int i = 0; i < 33; i++) push_w(DATA_W'($urandom));
    chk("t2_ready_low", 32'(last_ready), 32'd0);
    rd(2'd1);
    chk("t2_full", 32'(last_rd[29]), 32'd1);
    chk("t2_bp_sticky", 32'(last_rd[31]), 32'd1);
    rd(2'd0);
    idle(); chk("t2_ready_rise", 32'(last_ready), 32'd1);
    drain();
    wr(2'd3, 32'h4);
    rd(2'd1); chk("t2_bp_cleared", 32'(last_rd[31]), 32'd0);

    // 3: DATA read on empty stalls until a word lands.
    mm_read = 1'b1; mm_address = 2'd0;
    repeat (10) step();
    chk("t3_wait_held", 32'(last_wait), 32'd1);
    st_valid = 1'b1; st_data = DATA_W'(12'h055);
    step();
    st_valid = 1'b0;
    step();
    chk("t3_wait_drop", 32'(last_wait), 32'd0);
    chk("t3_data", last_rd, 32'h55);
    mm_read = 1'b0;
    rd(2'd1); chk("t3_level0", 32'(last_rd[15:0]), 32'd0);

    // 4: 100 cycles of concurrent push+pop at level 16.
    for (int i = 0; i < 16; i++) push_w(DATA_W'($urandom));
    for (int i = 0; i < 100; i++) begin
      st_valid = 1'b1; st_data = DATA_W'($urandom);
      mm_read = 1'b1; mm_address = 2'd0;
      step();
    end
    st_valid = 1'b0; mm_read = 1'b0;
    rd(2'd1); chk("t4_level16", 32'(last_rd[15:0]), 32'd16);
    drain();

    // 5: almost-full interrupt timing and threshold clamping.
    wr(2'd2, 32'd8);
    wr(2'd3, 32'h2);
    for (int i = 0; i < 8; i++) push_w(DATA_W'($urandom));
    idle(); chk("t5_irq_lag", 32'(last_irq), 32'd0);
    idle(); chk("t5_irq_set", 32'(last_irq), 32'd1);
    rd(2'd0);
    idle();
    idle(); chk("t5_irq_clear", 32'(last_irq), 32'd0);
    wr(2'd2, 32'd0);
    rd(2'd2); chk("t5_afull_min", last_rd, 32'd1);
    wr(2'd2, 32'd100);
    rd(2'd2); chk("t5_afull_max", last_rd, 32'd32);
    wr(2'd3, 32'h0);
    drain();

    // 6: flush at level 20 with a concurrent push; narrow data zero-extends.
    for (int i = 0; i < 20; i++) push_w(DATA_W'($urandom));
    st_valid = 1'b1; st_data = DATA_W'(12'hABC);
    wr(2'd3, 32'h1);
    st_valid = 1'b0;
    rd(2'd1); chk("t6_flushed", last_rd, 32'h1000_0000);
    push_w(DATA_W'(12'hFFF));
    rd(2'd0); chk("t6_zero_ext", last_rd, 32'h0000_0FFF);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      st_valid = 1'($urandom_range(0, 1));
      st_data  = DATA_W'($urandom);
      mm_write = ($urandom_range(0, 7) == 0);
      mm_read  = !mm_write && ($urandom_range(0, 2) != 0);
      mm_address = 2'($urandom);
      mm_writedata = $urandom;
      if ($urandom_range(0, 3) != 0) mm_writedata[0] = 1'b0;
      step();
    end
    st_valid = 1'b0; mm_read = 1'b0; mm_write = 1'b0;
    drain();

    // Reset during a stalled DATA read releases the master immediately.
    wr(2'd2, 32'd1);
    wr(2'd3, 32'h2);
    push_w(DATA_W'(12'h123));
    idle();
    rd(2'd0);
    mm_read = 1'b1; mm_address = 2'd0;
    step();
    chk("rr_wait_before", 32'(last_wait), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rr_wait_drop", 32'(mm_waitrequest), 32'd0);
    chk("rr_ready_low", 32'(st_ready), 32'd0);
    chk("rr_irq_low", 32'(irq), 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1; mm_read = 1'b0;
    rd(2'd1); chk("rr_status", last_rd, 32'h1000_0000);
    rd(2'd3); chk("rr_ctrl", last_rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
